// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, reset PC,
// FSM state encoding and instruction field extraction helpers.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_RETRY = 2'd2
  } fetch_state_t;

  function automatic logic [5:0] f_opcode(input logic [XLEN-1:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [15:0] f_imm(input logic [XLEN-1:0] inst);
    return inst[15:0];
  endfunction

  function automatic logic [25:0] f_target(input logic [XLEN-1:0] inst);
    return inst[25:0];
  endfunction

endpackage

// File: rtl/if_fetch_unit_npc_calc.sv
// Next-PC selection for the held instruction: jr, then j/jal, then taken
// branch, otherwise fall-through to PC+4.
module if_fetch_unit_npc_calc
  import if_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_inst,
  input  logic            i_ct_jr,
  input  logic            i_ct_jump,
  input  logic            i_ct_branch,
  input  logic            i_alu_zero,
  input  logic [XLEN-1:0] i_rs_data,
  output logic [XLEN-1:0] o_npc,
  output logic            o_misalign
);

  logic [15:0]     w_imm;
  logic [25:0]     w_target;
  logic [XLEN-1:0] w_br_off;

  assign w_imm    = f_imm(i_inst);
  assign w_target = f_target(i_inst);
  assign w_br_off = {{14{w_imm[15]}}, w_imm, 2'b00};

  always_comb begin
    o_npc      = i_pc_plus4;
    o_misalign = 1'b0;
    if (i_ct_jr) begin
      o_npc      = {i_rs_data[31:2], 2'b00};
      o_misalign = |i_rs_data[1:0];
    end else if (i_ct_jump) begin
      o_npc = {i_pc_plus4[31:28], w_target, 2'b00};
    end else if (i_ct_branch && i_alu_zero) begin
      o_npc = i_pc_plus4 + w_br_off;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-beat memory requests
// with timeout/retry, and holds the fetched word for decode until accepted.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              TIMEOUT  = 16,
  parameter int              CNT_W    = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_im_req,
  output logic [XLEN-1:0] o_im_addr,
  input  logic            i_im_ack,
  input  logic [XLEN-1:0] i_im_rdata,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst_out,
  output logic [XLEN-1:0] o_inst_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  input  logic            i_ct_branch,
  input  logic            i_alu_zero,
  input  logic            i_ct_jump,
  input  logic            i_ct_jr,
  input  logic [XLEN-1:0] i_rs_data,
  output logic            o_fetch_err,
  output logic            o_addr_err
);

  fetch_state_t    r_state, w_state_next;
  logic            r_req;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_pc, r_inst, r_inst_pc;
  logic            r_fetch_err, r_addr_err;

  logic            w_ack, w_timeout, w_handoff, w_misalign;
  logic [XLEN-1:0] w_pc_plus4, w_npc;

  // r_req is only ever set while the FSM sits in FETCH, so it doubles as the
  // "request is live" qualifier; acks seen without it are stale and dropped.
  assign w_ack      = r_req & i_im_ack;
  assign w_timeout  = r_req & ~i_im_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_handoff  = (r_state == S_VALID) & i_inst_ready;
  assign w_pc_plus4 = r_inst_pc + 32'd4;

  if_fetch_unit_npc_calc u_npc_calc (
    .i_pc_plus4  (w_pc_plus4),
    .i_inst      (r_inst),
    .i_ct_jr     (i_ct_jr),
    .i_ct_jump   (i_ct_jump),
    .i_ct_branch (i_ct_branch),
    .i_alu_zero  (i_alu_zero),
    .i_rs_data   (i_rs_data),
    .o_npc       (w_npc),
    .o_misalign  (w_misalign)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_ack) begin
          w_state_next = S_VALID;
        end else if (w_timeout) begin
          w_state_next = S_RETRY;
        end
      end
      S_VALID: if (i_inst_ready) w_state_next = S_FETCH;
      S_RETRY: w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= (w_state_next == S_FETCH);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_req && !w_ack && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      r_fetch_err <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_fetch_err <= w_timeout;
      if (w_ack) begin
        r_inst    <= i_im_rdata;
        r_inst_pc <= r_pc;
      end
      if (w_handoff) begin
        r_pc <= w_npc;
        if (w_misalign) r_addr_err <= 1'b1;
      end
    end
  end

  assign o_im_req     = r_req;
  assign o_im_addr    = r_pc;
  assign o_inst_valid = (r_state == S_VALID);
  assign o_inst_out   = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_pc_plus4   = w_pc_plus4;
  assign o_fetch_err  = r_fetch_err;
  assign o_addr_err   = r_addr_err;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed steps plus randomized
// transactions compared against a next-PC reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;
  localparam int          CNT_W    = 5;

  logic        clk;
  logic        rstN;
  logic        imReq;
  logic [31:0] imAddr;
  logic        imAck;
  logic [31:0] imRdata;
  logic        instValid;
  logic        instReady;
  logic [31:0] instOut;
  logic [31:0] instPc;
  logic [31:0] pcPlus4;
  logic        ctBranch;
  logic        aluZero;
  logic        ctJump;
  logic        ctJr;
  logic [31:0] rsData;
  logic        fetchErr;
  logic        addrErr;

  int          passCount;
  int          checkCount;
  logic [31:0] modelPc;
  logic        modelAddrErr;

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .o_im_req     (imReq),
    .o_im_addr    (imAddr),
    .i_im_ack     (imAck),
    .i_im_rdata   (imRdata),
    .o_inst_valid (instValid),
    .i_inst_ready (instReady),
    .o_inst_out   (instOut),
    .o_inst_pc    (instPc),
    .o_pc_plus4   (pcPlus4),
    .i_ct_branch  (ctBranch),
    .i_alu_zero   (aluZero),
    .i_ct_jump    (ctJump),
    .i_ct_jr      (ctJr),
    .i_rs_data    (rsData),
    .o_fetch_err  (fetchErr),
    .o_addr_err   (addrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Next PC from the ISA rules, using plain arithmetic on the fetch address.
  function automatic logic [31:0] refNpc(input logic [31:0] pcVal, input logic [31:0] instr,
                                         input bit jr, input bit jump, input bit br,
                                         input bit zero, input logic [31:0] rs);
    logic [31:0] link;
    logic [15:0] immField;
    int          off;
    link     = pcVal + 32'd4;
    immField = instr[15:0];
    off      = int'($signed(immField));
    if (jr) return rs - (rs % 32'd4);
    if (jump) return (link & 32'hF000_0000) | ((instr % 32'h0400_0000) * 32'd4);
    if (br && zero) return link + 32'(off * 4);
    return link;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic randomizeControls();
    ctJr     = 1'($urandom_range(0, 1));
    ctJump   = 1'($urandom_range(0, 1));
    ctBranch = 1'($urandom_range(0, 1));
    aluZero  = 1'($urandom_range(0, 1));
    rsData   = $urandom;
  endtask

  task automatic waitForReq();
    int waitCnt;
    waitCnt = 0;
    while (imReq !== 1'b1 && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("req_high", 32'(imReq), 32'd1);
  endtask

  // One full fetch: ack after lat cycles, hold for hold cycles, then hand off.
  task automatic applyStimulus(input int lat, input int hold, input logic [31:0] instr,
                               input bit jr, input bit jump, input bit br, input bit zero,
                               input logic [31:0] rs);
    logic [31:0] expNpc;
    waitForReq();
    checkOutput("im_addr", imAddr, modelPc);
    repeat (lat) begin
      imAck   = 1'b0;
      imRdata = $urandom;
      randomizeControls();
      @(negedge clk);
    end
    imAck   = 1'b1;
    imRdata = instr;
    @(negedge clk);
    imAck   = 1'b0;
    imRdata = $urandom;
    checkOutput("valid_high", 32'(instValid), 32'd1);
    checkOutput("inst_out", instOut, instr);
    checkOutput("inst_pc", instPc, modelPc);
    checkOutput("pc_plus4", pcPlus4, modelPc + 32'd4);
    checkOutput("req_low_valid", 32'(imReq), 32'd0);
    repeat (hold) begin
      instReady = 1'b0;
      imAck     = 1'($urandom_range(0, 1));
      imRdata   = $urandom;
      randomizeControls();
      @(negedge clk);
      imAck = 1'b0;
      checkOutput("hold_inst", instOut, instr);
      checkOutput("hold_pc", instPc, modelPc);
      checkOutput("hold_valid", 32'(instValid), 32'd1);
    end
    instReady = 1'b1;
    ctJr      = jr;
    ctJump    = jump;
    ctBranch  = br;
    aluZero   = zero;
    rsData    = rs;
    expNpc    = refNpc(modelPc, instr, jr, jump, br, zero, rs);
    if (jr && (rs % 32'd4) != 32'd0) modelAddrErr = 1'b1;
    @(negedge clk);
    instReady = 1'b0;
    randomizeControls();
    modelPc = expNpc;
    checkOutput("valid_low", 32'(instValid), 32'd0);
    checkOutput("npc", imAddr, modelPc);
    checkOutput("req_next", 32'(imReq), 32'd1);
    checkOutput("addr_err", 32'(addrErr), 32'(modelAddrErr));
  endtask

  task automatic checkTimeout();
    waitForReq();
    imAck = 1'b0;
    for (int c = 1; c < TIMEOUT; c++) begin
      @(negedge clk);
      checkOutput("to_req_held", 32'(imReq), 32'd1);
      checkOutput("to_no_err", 32'(fetchErr), 32'd0);
    end
    @(negedge clk);
    checkOutput("to_req_low", 32'(imReq), 32'd0);
    checkOutput("to_fetch_err", 32'(fetchErr), 32'd1);
    imAck   = 1'b1;
    imRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imAck = 1'b0;
    checkOutput("retry_req", 32'(imReq), 32'd1);
    checkOutput("retry_err_clr", 32'(fetchErr), 32'd0);
    checkOutput("retry_no_valid", 32'(instValid), 32'd0);
    checkOutput("retry_addr", imAddr, modelPc);
  endtask

  initial begin
    logic [31:0] rndInstr;
    logic [31:0] rndRs;
    passCount    = 0;
    checkCount   = 0;
    rstN         = 1'b0;
    imAck        = 1'b0;
    imRdata      = '0;
    instReady    = 1'b0;
    ctBranch     = 1'b0;
    aluZero      = 1'b0;
    ctJump       = 1'b0;
    ctJr         = 1'b0;
    rsData       = '0;
    modelPc      = RESET_PC;
    modelAddrErr = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req", 32'(imReq), 32'd0);
    checkOutput("rst_valid", 32'(instValid), 32'd0);
    checkOutput("rst_inst", instOut, 32'd0);
    checkOutput("rst_inst_pc", instPc, 32'd0);
    checkOutput("rst_addr", imAddr, RESET_PC);
    checkOutput("rst_fetch_err", 32'(fetchErr), 32'd0);
    checkOutput("rst_addr_err", 32'(addrErr), 32'd0);
    rstN = 1'b1;
    checkOutput("release_req_low", 32'(imReq), 32'd0);
    @(negedge clk);
    checkOutput("release_req_up", 32'(imReq), 32'd1);

    $display("[TB] directed fetch and hold");
    applyStimulus(0, 0, 32'h2408_0005, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 5, 32'h0000_0020, 0, 0, 0, 0, 32'h0);

    $display("[TB] directed branches and jumps");
    applyStimulus(1, 0, 32'h1000_FFFE, 0, 0, 1, 1, 32'h0);
    applyStimulus(0, 0, 32'h0000_0000, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 32'h1000_FFFE, 0, 0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h03E0_0008, 1, 0, 0, 0, 32'h1000_0010);
    applyStimulus(2, 1, 32'h0800_0040, 0, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 32'h03E0_0008, 1, 1, 0, 0, 32'h0000_3006);
    applyStimulus(0, 0, 32'h0000_0000, 0, 0, 0, 0, 32'h0);

    $display("[TB] timeout and retry");
    checkTimeout();
    applyStimulus(TIMEOUT - 1, 0, 32'h2409_0001, 0, 0, 0, 0, 32'h0);

    $display("[TB] address wrap");
    applyStimulus(0, 0, 32'h03E0_0008, 1, 0, 0, 0, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 32'h0000_0000, 0, 0, 0, 0, 32'h0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      rndInstr = $urandom;
      rndRs    = $urandom;
      if ($urandom_range(0, 1) == 0) rndRs = rndRs & 32'hFFFF_FFFC;
      applyStimulus($urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3), rndInstr,
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rndRs);
    end

    $display("[TB] asynchronous reset while holding");
    applyStimulus(0, 0, 32'h03E0_0008, 1, 0, 0, 0, 32'h0000_0040);
    waitForReq();
    imAck   = 1'b1;
    imRdata = 32'h2408_1234;
    @(negedge clk);
    imAck = 1'b0;
    checkOutput("pre_rst_valid", 32'(instValid), 32'd1);
    checkOutput("pre_rst_pc", instPc, 32'h0000_0040);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(instValid), 32'd0);
    checkOutput("arst_req", 32'(imReq), 32'd0);
    checkOutput("arst_inst", instOut, 32'd0);
    checkOutput("arst_inst_pc", instPc, 32'd0);
    checkOutput("arst_addr", imAddr, RESET_PC);
    checkOutput("arst_addr_err", 32'(addrErr), 32'd0);
    @(negedge clk);
    rstN         = 1'b1;
    modelPc      = RESET_PC;
    modelAddrErr = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req", 32'(imReq), 32'd1);
    checkOutput("post_rst_addr", imAddr, RESET_PC);
    applyStimulus(0, 1, 32'h2408_0005, 0, 0, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
